de_input_conditioner: RTL and testbench

//   Parametrised front end for DE-series board inputs (KEY, SW) feeding game/VGA logic.

---
 rtl/de_input_conditioner.sv | 204 ++++++++++++++++++++
 tb/tb_de_input_conditioner.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/de_input_conditioner.sv
// rtl/de_input_conditioner.sv - reset release, key debounce/edge detect and switch sync for DE boards
// Each key runs its own 4-state debounce FSM; switches are only synchronised.
module de_input_conditioner #(
   parameter int NUM_KEYS        = 3,
   parameter int NUM_SW          = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RST_HOLD_CYCLES = 16
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic [NUM_KEYS-1:0] key_n_in,
   input  logic [NUM_SW-1:0]   sw_in,
   output logic                sys_resetn,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_SW-1:0]   sw_level,
   output logic                sw_change
);

   localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARM_PRESS = 2'd1,
      PRESSED   = 2'd2,
      ARM_REL   = 2'd3
   } key_state_e;

   logic [1:0]    rst_sync_q, rst_sync_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          sys_resetn_q, sys_resetn_d;

   // sys_resetn rises on the edge where the hold count reaches RST_HOLD_CYCLES
   always_comb begin
      rst_sync_d   = {rst_sync_q[0], 1'b1};
      hold_cnt_d   = hold_cnt_q;
      sys_resetn_d = sys_resetn_q;
      if (rst_sync_q[1] && !sys_resetn_q) begin
         hold_cnt_d = hold_cnt_q + HW'(1);
         if (hold_cnt_q == HOLD_LAST) begin
            sys_resetn_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         rst_sync_q   <= '0;
         hold_cnt_q   <= '0;
         sys_resetn_q <= 1'b0;
      end else begin
         rst_sync_q   <= rst_sync_d;
         hold_cnt_q   <= hold_cnt_d;
         sys_resetn_q <= sys_resetn_d;
      end
   end

   logic [NUM_KEYS-1:0] key_s1_q, key_s1_d;
   logic [NUM_KEYS-1:0] key_s2_q, key_s2_d;
   logic [NUM_KEYS-1:0] key_level_q, key_level_d;
   logic [NUM_KEYS-1:0] key_prev_q, key_prev_d;
   logic [NUM_KEYS-1:0] key_press_q, key_press_d;
   logic [NUM_KEYS-1:0] key_release_q, key_release_d;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_state_e    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          s;

      assign s = key_s2_q[i];

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         if (!sys_resetn_q) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (s) begin
                     state_d = ARM_PRESS;
                     cnt_d   = CW'(1);
                  end
               end
               ARM_PRESS: begin
                  if (!s) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_MAX) begin
                     state_d = PRESSED;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
               PRESSED: begin
                  if (!s) begin
                     state_d = ARM_REL;
                     cnt_d   = CW'(1);
                  end
               end
               ARM_REL: begin
                  if (s) begin
                     state_d = PRESSED;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_MAX) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end

      // Level follows the next state so it changes on the same edge as the FSM
      assign key_level_d[i] = (state_d == PRESSED) || (state_d == ARM_REL);

      always_ff @(posedge CLOCK_50 or negedge resetn) begin
         if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end
   end

   always_comb begin
      key_s1_d      = ~key_n_in;
      key_s2_d      = key_s1_q;
      key_prev_d    = key_level_q;
      key_press_d   = key_level_q & ~key_prev_q;
      key_release_d = ~key_level_q & key_prev_q;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         key_s1_q      <= '0;
         key_s2_q      <= '0;
         key_level_q   <= '0;
         key_prev_q    <= '0;
         key_press_q   <= '0;
         key_release_q <= '0;
      end else begin
         key_s1_q      <= key_s1_d;
         key_s2_q      <= key_s2_d;
         key_level_q   <= key_level_d;
         key_prev_q    <= key_prev_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
      end
   end

   logic [NUM_SW-1:0] sw_s1_q, sw_s1_d;
   logic [NUM_SW-1:0] sw_s2_q, sw_s2_d;
   logic [NUM_SW-1:0] sw_level_q, sw_level_d;
   logic              sw_seen_q, sw_seen_d;
   logic              sw_change_q, sw_change_d;

   // sw_seen_q stays low through the first capture so the initial value never pulses
   always_comb begin
      sw_s1_d     = sw_in;
      sw_s2_d     = sw_s1_q;
      sw_level_d  = sys_resetn_q ? sw_s2_q : '0;
      sw_seen_d   = sw_seen_q | sys_resetn_q;
      sw_change_d = sw_seen_q && (sw_level_d != sw_level_q);
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
         sw_level_q  <= '0;
         sw_seen_q   <= 1'b0;
         sw_change_q <= 1'b0;
      end else begin
         sw_s1_q     <= sw_s1_d;
         sw_s2_q     <= sw_s2_d;
         sw_level_q  <= sw_level_d;
         sw_seen_q   <= sw_seen_d;
         sw_change_q <= sw_change_d;
      end
   end

   assign sys_resetn  = sys_resetn_q;
   assign key_level   = key_level_q;
   assign key_press   = key_press_q;
   assign key_release = key_release_q;
   assign sw_level    = sw_level_q;
   assign sw_change   = sw_change_q;

endmodule

// File: tb/tb_de_input_conditioner.sv
// tb/tb_de_input_conditioner.sv - directed self-checking bench for de_input_conditioner
module tb_de_input_conditioner;

   logic       clk;
   logic       resetn;
   logic [2:0] key_n_in;
   logic [9:0] sw_in;
   logic       sys_resetn;
   logic [2:0] key_level, key_press, key_release;
   logic [9:0] sw_level;
   logic       sw_change;

   int checks = 0;
   int errors = 0;

   de_input_conditioner #(
      .NUM_KEYS(3),
      .NUM_SW(10),
      .DEBOUNCE_CYCLES(4),
      .RST_HOLD_CYCLES(8)
   ) dut (
      .CLOCK_50(clk),
      .resetn(resetn),
      .key_n_in(key_n_in),
      .sw_in(sw_in),
      .sys_resetn(sys_resetn),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release),
      .sw_level(sw_level),
      .sw_change(sw_change)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [2:0] key_n;
      logic [2:0] lvl;
      logic [2:0] prs;
      logic [2:0] rel;
   } vec_t;

   vec_t vecs[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " sys_resetn"}, 32'(sys_resetn), 32'd0);
      chk({tag, " key_level"}, 32'(key_level), 32'd0);
      chk({tag, " key_press"}, 32'(key_press), 32'd0);
      chk({tag, " key_release"}, 32'(key_release), 32'd0);
      chk({tag, " sw_level"}, 32'(sw_level), 32'd0);
      chk({tag, " sw_change"}, 32'(sw_change), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 22; i++) vecs[i] = '{3'b111, 3'b000, 3'b000, 3'b000};
      for (int i = 0; i <= 5; i++) vecs[i] = '{3'b110, 3'b000, 3'b000, 3'b000};
      vecs[6]  = '{3'b110, 3'b001, 3'b000, 3'b000};
      vecs[7]  = '{3'b110, 3'b001, 3'b001, 3'b000};
      vecs[8]  = '{3'b110, 3'b001, 3'b000, 3'b000};
      vecs[9]  = '{3'b110, 3'b001, 3'b000, 3'b000};
      vecs[10] = '{3'b110, 3'b001, 3'b000, 3'b000};
      for (int i = 11; i <= 16; i++) vecs[i] = '{3'b111, 3'b001, 3'b000, 3'b000};
      vecs[17] = '{3'b111, 3'b000, 3'b000, 3'b000};
      vecs[18] = '{3'b111, 3'b000, 3'b000, 3'b001};

      // Reset, hold release and initial switch capture
      resetn   = 1'b0;
      key_n_in = 3'b111;
      sw_in    = 10'h0A5;
      #5;
      chk_all_zero("reset_async");
      repeat (10) @(posedge clk);
      #1;
      chk_all_zero("reset_held");
      resetn = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         chk($sformatf("rst_rel e%0d sys_resetn", e), 32'(sys_resetn), (e == 10) ? 32'd1 : 32'd0);
         chk($sformatf("rst_rel e%0d sw_level", e), 32'(sw_level), 32'd0);
         chk($sformatf("rst_rel e%0d key_level", e), 32'(key_level), 32'd0);
      end
      for (int e = 11; e <= 12; e++) begin
         step();
         chk($sformatf("sw_init e%0d sw_level", e), 32'(sw_level), 32'h0A5);
         chk($sformatf("sw_init e%0d sw_change", e), 32'(sw_change), 32'd0);
      end

      // Switch change after initial capture
      sw_in = 10'h0A4;
      begin
         int pulses = 0;
         for (int j = 1; j <= 8; j++) begin
            step();
            if (sw_change === 1'b1) pulses++;
            chk($sformatf("sw_chg j%0d sw_change", j), 32'(sw_change), (j == 3) ? 32'd1 : 32'd0);
         end
         chk("sw_chg pulse_count", 32'(pulses), 32'd1);
         chk("sw_chg sw_level", 32'(sw_level), 32'h0A4);
      end

      // Table: key 0 press, hold without repeat, release
      for (int i = 0; i < 22; i++) begin
         key_n_in = vecs[i].key_n;
         step();
         chk($sformatf("vec%0d key_level", i), 32'(key_level), 32'(vecs[i].lvl));
         chk($sformatf("vec%0d key_press", i), 32'(key_press), 32'(vecs[i].prs));
         chk($sformatf("vec%0d key_release", i), 32'(key_release), 32'(vecs[i].rel));
         chk($sformatf("vec%0d sw_change", i), 32'(sw_change), 32'd0);
      end

      // Key 1 bounce: low 2, high 1, low 10, then released
      for (int j = 1; j <= 30; j++) begin
         key_n_in = (j <= 2 || (j >= 4 && j <= 13)) ? 3'b101 : 3'b111;
         step();
         chk($sformatf("bounce j%0d key_press", j), 32'(key_press), (j == 11) ? 32'd2 : 32'd0);
         chk($sformatf("bounce j%0d key_release", j), 32'(key_release), (j == 21) ? 32'd2 : 32'd0);
      end

      // Keys 0 and 2 together
      for (int j = 1; j <= 35; j++) begin
         key_n_in = (j <= 20) ? 3'b010 : 3'b111;
         step();
         chk($sformatf("dual j%0d key_press", j), 32'(key_press), (j == 8) ? 32'd5 : 32'd0);
         chk($sformatf("dual j%0d key_release", j), 32'(key_release), (j == 28) ? 32'd5 : 32'd0);
      end

      // Reset pulse while key 0 held
      key_n_in = 3'b110;
      for (int j = 1; j <= 10; j++) step();
      chk("rstmid pre key_level", 32'(key_level), 32'd1);
      resetn = 1'b0;
      #2;
      chk_all_zero("rstmid async");
      for (int j = 1; j <= 3; j++) begin
         step();
         chk($sformatf("rstmid hold%0d key_release", j), 32'(key_release), 32'd0);
         chk($sformatf("rstmid hold%0d key_level", j), 32'(key_level), 32'd0);
      end
      resetn = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         step();
         chk($sformatf("rstmid j%0d sys_resetn", j), 32'(sys_resetn), (j >= 10) ? 32'd1 : 32'd0);
         chk($sformatf("rstmid j%0d key_level", j), 32'(key_level), (j >= 15) ? 32'd1 : 32'd0);
         chk($sformatf("rstmid j%0d key_press", j), 32'(key_press), (j == 16) ? 32'd1 : 32'd0);
         chk($sformatf("rstmid j%0d key_release", j), 32'(key_release), 32'd0);
         chk($sformatf("rstmid j%0d sw_change", j), 32'(sw_change), 32'd0);
      end
      chk("rstmid sw_level", 32'(sw_level), 32'h0A4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
